tlb_lookup_unit: RTL
====================

// Module: tlb_lookup_unit
// PURPOSE
//  16-entry fully-associative LoongArch TLB: one registered search port, one read port,
//  one write port and INVTLB. Sits between the MEM-stage address path / CSR unit and the
//  4->16 / 16->4 index coders. Per-entry hit vector is one-hot reduced, then encoded to a 4-bit index.
//  Write index is decoded to a 16-bit entry select.
// PARAMETERS
//  TLBNUM     16  entry count; fixed by 4-bit index; any other value is illegal
//  ASID_W     10  ASID width
//  PALEN      32  physical address width (PPN = PALEN-12 = 20 bits)
// PORTS
//  clk          in   1   clock
//  resetn       in   1   asynchronous active-low reset
//  s_req        in   1   search request, sampled on clk
//  s_vppn       in   19  VA[31:13] of search
//  s_va_bit12   in   1   VA[12] of search
//  s_asid       in   10  current ASID
//  s_rvalid     out  1   search result valid, exactly 1 cycle after s_req
//  s_found      out  1   hit
//  s_index      out  4   hit entry index
//  s_lo         out  26  selected page half {ppn20,plv2,mat2,d1,v1}
//  s_ps         out  6   page size of hit entry
//  we           in   1   write enable
//  w_index      in   4   entry to write
//  w_hi         in   37  {vppn19,ps6,g1,asid10,e1}
//  w_lo0/w_lo1  in   26  even/odd page half, packed as s_lo
//  r_index      in   4   read index, sampled every cycle
//  r_hi         out  37  entry hi, registered (1 cycle)
//  r_lo0/r_lo1  out  26  entry lo halves, registered (1 cycle)
//  inv_valid    in   1   INVTLB strobe
//  inv_op       in   5   INVTLB op
//  inv_asid     in   10  INVTLB ASID operand
//  inv_vppn     in   19  INVTLB VA[31:13] operand
// BEHAVIOUR
//  Reset: every entry e=0 (other fields untouched); s_rvalid,s_found,s_index,s_lo,s_ps,r_* = 0.
//  Match(i): e && (g || asid==s_asid) && (ps==21 ? vppn[18:9]==s_vppn[18:9] : vppn==s_vppn).
//  Only ps=12 and ps=21 are legal; other ps values never match.
//  Odd select: ps==21 ? s_vppn[8] : s_va_bit12; 1 -> lo1, 0 -> lo0.
//  Search: match on s_req inputs at edge N; outputs registered, s_rvalid=1 for cycle N+1 only.
//  No s_req -> s_rvalid=0; s_found/s_index/s_lo/s_ps hold last value.
//  Miss: s_found=0, s_index=0, s_lo=0, s_ps=0.
//  Multi-hit is a software error; lowest matching index wins, deterministically.
//  Write: at edge when we=1, entry w_index <- {w_hi,w_lo0,w_lo1}.
//  Search/read in the same cycle see pre-write contents (no bypass).
//  Read: r_* <= entry[r_index] every edge, pre-write contents on same-cycle write.
//  INVTLB (clears e only), at edge when inv_valid=1:
//   op0/1 all; op2 g=1; op3 g=0; op4 g=0&&asid==inv_asid;
//   op5 g=0&&asid==inv_asid&&VA match; op6 (g||asid==inv_asid)&&VA match.
//   VA match uses entry ps rule above with inv_vppn. op>=7 no effect.
//  Same-cycle inv_valid and we: invalidate applied first, then write.
//  Result: written entry holds w_hi exactly.
//  Reset mid-search: pending s_rvalid dropped, no result ever emitted for that request.
// STRUCTURE
//  tlb_pkg: field widths, hi/lo bit offsets, PS_4K=12, PS_2M=21, INVTLB op codes.
//  Sub-module tlb_entry_match (one entry: match + odd-select + inv-hit), instanced TLBNUM times.
//  Hit reduction: priority one-hot mask, then encoder_16_4. Write select: decoder_4_16.
// TESTING
//  1 reset -> s_rvalid=0, all r_hi.e=0; any search -> s_found=0 next cycle.
//  2 write idx3 vppn=0x12345,ps12,asid5,g0,e1; search vppn 0x12345,bit12=1,asid5
//    -> next cycle s_found=1,s_index=3,s_lo=lo1.
//  3 ps21 entry idx7 vppn=0x2A400,g1; search vppn 0x2A5FF,asid 9 -> hit idx7;
//    s_vppn[8]=1 -> lo1 selected.
//  4 entries 2 and 9 both match -> s_index=2.
//    Same-cycle write idx2 + search -> old idx2 result, new value on next search.
//  5 invtlb op4 asid5 with g0/g1 entries asid5 -> only g0 entries cleared.
//    op7 -> no change. inv+we same idx -> entry valid with new data.
//  6 assert resetn low between s_req and result -> no s_rvalid pulse; entries e=0 afterwards.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared widths, entry field offsets, page sizes, INVTLB op codes and index coders for the TLB.
package tlb_pkg;

  localparam int unsigned TLBNUM = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned ASID_W = 10;
  localparam int unsigned PALEN  = 32;
  localparam int unsigned PPN_W  = PALEN - 12;
  localparam int unsigned VPPN_W = 19;
  localparam int unsigned PS_W   = 6;
  localparam int unsigned HI_W   = VPPN_W + PS_W + 1 + ASID_W + 1;
  localparam int unsigned LO_W   = PPN_W + 6;

  // Hi word layout: {vppn, ps, g, asid, e}
  localparam int unsigned HI_E         = 0;
  localparam int unsigned HI_ASID_LSB  = 1;
  localparam int unsigned HI_G         = HI_ASID_LSB + ASID_W;
  localparam int unsigned HI_PS_LSB    = HI_G + 1;
  localparam int unsigned HI_VPPN_LSB  = HI_PS_LSB + PS_W;

  // A 2 MB page compares only vppn[18:9]; vppn[8] picks the odd/even half.
  localparam int unsigned HUGE_LSB = 9;

  localparam logic [PS_W-1:0] PS_4K = 6'd12;
  localparam logic [PS_W-1:0] PS_2M = 6'd21;

  localparam logic [4:0] INV_ALL0       = 5'd0;
  localparam logic [4:0] INV_ALL1       = 5'd1;
  localparam logic [4:0] INV_G1         = 5'd2;
  localparam logic [4:0] INV_G0         = 5'd3;
  localparam logic [4:0] INV_G0_ASID    = 5'd4;
  localparam logic [4:0] INV_G0_ASID_VA = 5'd5;
  localparam logic [4:0] INV_ASID_VA    = 5'd6;

  // Page-number compare under the entry's page size; illegal sizes never match.
  function automatic logic vppn_match(input logic [VPPN_W-1:0] ent_vppn,
                                      input logic [PS_W-1:0]   ent_ps,
                                      input logic [VPPN_W-1:0] q_vppn);
    if (ent_ps == PS_2M) begin
      return ent_vppn[VPPN_W-1:HUGE_LSB] == q_vppn[VPPN_W-1:HUGE_LSB];
    end else if (ent_ps == PS_4K) begin
      return ent_vppn == q_vppn;
    end
    return 1'b0;
  endfunction

  // One-hot to binary; input must have at most one bit set.
  function automatic logic [IDX_W-1:0] encoder_16_4(input logic [TLBNUM-1:0] onehot);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      if (onehot[i]) idx |= IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [TLBNUM-1:0] decoder_4_16(input logic [IDX_W-1:0] idx);
    logic [TLBNUM-1:0] sel;
    sel      = '0;
    sel[idx] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/tlb_entry_match.sv
// Per-entry comparators: search hit, odd-half select and INVTLB hit.
module tlb_entry_match
  import tlb_pkg::*;
(
  input  logic              e,
  input  logic              g,
  input  logic [ASID_W-1:0] asid,
  input  logic [VPPN_W-1:0] vppn,
  input  logic [PS_W-1:0]   ps,
  input  logic [VPPN_W-1:0] s_vppn,
  input  logic              s_va_bit12,
  input  logic [ASID_W-1:0] s_asid,
  input  logic [4:0]        inv_op,
  input  logic [ASID_W-1:0] inv_asid,
  input  logic [VPPN_W-1:0] inv_vppn,
  output logic              s_match,
  output logic              s_odd,
  output logic              inv_hit
);

  logic inv_asid_eq;
  logic inv_va_eq;

  // Search match and odd/even half selection
  always_comb begin
    s_match = e && (g || (asid == s_asid)) && vppn_match(vppn, ps, s_vppn);
    s_odd   = (ps == PS_2M) ? s_vppn[HUGE_LSB-1] : s_va_bit12;
  end

  // INVTLB selection; only e is cleared by the caller, so ops ignore e here
  always_comb begin
    inv_asid_eq = (asid == inv_asid);
    inv_va_eq   = vppn_match(vppn, ps, inv_vppn);
    inv_hit     = 1'b0;
    case (inv_op)
      INV_ALL0, INV_ALL1: inv_hit = 1'b1;
      INV_G1:             inv_hit = g;
      INV_G0:             inv_hit = !g;
      INV_G0_ASID:        inv_hit = !g && inv_asid_eq;
      INV_G0_ASID_VA:     inv_hit = !g && inv_asid_eq && inv_va_eq;
      INV_ASID_VA:        inv_hit = (g || inv_asid_eq) && inv_va_eq;
      default:            inv_hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/tlb_lookup_unit.sv
// 16-entry fully-associative TLB with registered search, registered read, write and INVTLB.
module tlb_lookup_unit
  import tlb_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              s_req,
  input  logic [VPPN_W-1:0] s_vppn,
  input  logic              s_va_bit12,
  input  logic [ASID_W-1:0] s_asid,
  output logic              s_rvalid,
  output logic              s_found,
  output logic [IDX_W-1:0]  s_index,
  output logic [LO_W-1:0]   s_lo,
  output logic [PS_W-1:0]   s_ps,
  input  logic              we,
  input  logic [IDX_W-1:0]  w_index,
  input  logic [HI_W-1:0]   w_hi,
  input  logic [LO_W-1:0]   w_lo0,
  input  logic [LO_W-1:0]   w_lo1,
  input  logic [IDX_W-1:0]  r_index,
  output logic [HI_W-1:0]   r_hi,
  output logic [LO_W-1:0]   r_lo0,
  output logic [LO_W-1:0]   r_lo1,
  input  logic              inv_valid,
  input  logic [4:0]        inv_op,
  input  logic [ASID_W-1:0] inv_asid,
  input  logic [VPPN_W-1:0] inv_vppn
);

  // Entry storage: only e is reset, the rest keeps whatever was last written
  logic [TLBNUM-1:0] e_q, e_d;
  logic [TLBNUM-1:0] g_q;
  logic [VPPN_W-1:0] vppn_q [TLBNUM];
  logic [PS_W-1:0]   ps_q   [TLBNUM];
  logic [ASID_W-1:0] asid_q [TLBNUM];
  logic [LO_W-1:0]   lo0_q  [TLBNUM];
  logic [LO_W-1:0]   lo1_q  [TLBNUM];

  logic [TLBNUM-1:0] s_match, s_odd, inv_hit, hit_oh, w_sel;
  logic [LO_W-1:0]   sel_lo;
  logic [PS_W-1:0]   sel_ps;
  logic [IDX_W-1:0]  sel_idx;
  logic              any_hit;

  logic              s_rvalid_q, s_found_q;
  logic [IDX_W-1:0]  s_index_q;
  logic [LO_W-1:0]   s_lo_q, lo_rd0_q, lo_rd1_q;
  logic [PS_W-1:0]   s_ps_q;
  logic [HI_W-1:0]   r_hi_q;

  for (genvar i = 0; i < TLBNUM; i++) begin : g_entry
    tlb_entry_match u_match (
      .e          (e_q[i]),
      .g          (g_q[i]),
      .asid       (asid_q[i]),
      .vppn       (vppn_q[i]),
      .ps         (ps_q[i]),
      .s_vppn     (s_vppn),
      .s_va_bit12 (s_va_bit12),
      .s_asid     (s_asid),
      .inv_op     (inv_op),
      .inv_asid   (inv_asid),
      .inv_vppn   (inv_vppn),
      .s_match    (s_match[i]),
      .s_odd      (s_odd[i]),
      .inv_hit    (inv_hit[i])
    );
  end

  // Lowest-index hit wins; the one-hot mask then drives encoder and data mux
  always_comb begin
    hit_oh  = s_match & (~s_match + {{(TLBNUM-1){1'b0}}, 1'b1});
    any_hit = |s_match;
    sel_idx = encoder_16_4(hit_oh);
    sel_lo  = '0;
    sel_ps  = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      if (hit_oh[i]) begin
        sel_lo |= s_odd[i] ? lo1_q[i] : lo0_q[i];
        sel_ps |= ps_q[i];
      end
    end
  end

  // Valid-bit next state: invalidate first so a same-cycle write lands intact
  always_comb begin
    w_sel = decoder_4_16(w_index);
    e_d   = e_q;
    if (inv_valid) e_d = e_d & ~inv_hit;
    for (int i = 0; i < TLBNUM; i++) begin
      if (we && w_sel[i]) e_d[i] = w_hi[HI_E];
    end
  end

  // Valid bits, cleared on reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_q <= '0;
    end else begin
      e_q <= e_d;
    end
  end

  // Entry payload write, no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < TLBNUM; i++) begin
      if (we && w_sel[i]) begin
        vppn_q[i] <= w_hi[HI_VPPN_LSB +: VPPN_W];
        ps_q[i]   <= w_hi[HI_PS_LSB +: PS_W];
        g_q[i]    <= w_hi[HI_G];
        asid_q[i] <= w_hi[HI_ASID_LSB +: ASID_W];
        lo0_q[i]  <= w_lo0;
        lo1_q[i]  <= w_lo1;
      end
    end
  end

  // Search result register; data holds when no request is made
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_rvalid_q <= 1'b0;
      s_found_q  <= 1'b0;
      s_index_q  <= '0;
      s_lo_q     <= '0;
      s_ps_q     <= '0;
    end else begin
      s_rvalid_q <= s_req;
      if (s_req) begin
        s_found_q <= any_hit;
        s_index_q <= sel_idx;
        s_lo_q    <= sel_lo;
        s_ps_q    <= sel_ps;
      end
    end
  end

  // Read port register, sees pre-write contents
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi_q   <= '0;
      lo_rd0_q <= '0;
      lo_rd1_q <= '0;
    end else begin
      r_hi_q   <= {vppn_q[r_index], ps_q[r_index], g_q[r_index], asid_q[r_index], e_q[r_index]};
      lo_rd0_q <= lo0_q[r_index];
      lo_rd1_q <= lo1_q[r_index];
    end
  end

  assign s_rvalid = s_rvalid_q;
  assign s_found  = s_found_q;
  assign s_index  = s_index_q;
  assign s_lo     = s_lo_q;
  assign s_ps     = s_ps_q;
  assign r_hi     = r_hi_q;
  assign r_lo0    = lo_rd0_q;
  assign r_lo1    = lo_rd1_q;

endmodule
